// File: rtl/imm_pkg.sv
// Shared definitions for the immediate extender: mode encodings, default widths
// and the combine FSM state type.
package imm_pkg;

  localparam int unsigned IMM_IN_W = 12;
  localparam int unsigned DATA_W   = 16;

  localparam logic [1:0] IMM_ZERO = 2'b00;
  localparam logic [1:0] IMM_SIGN = 2'b01;
  localparam logic [1:0] IMM_HI   = 2'b10;
  localparam logic [1:0] IMM_LO   = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StHeld
  } comb_state_e;

  // Every mode except HI yields an output word.
  function automatic logic imm_produces_result(input logic [1:0] mode);
    return mode != IMM_HI;
  endfunction

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational extension mux: zero-extend, sign-extend, or splice the held
// upper bits above the incoming LO field.
module imm_ext_comb
  import imm_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_IN_W,
  parameter int unsigned OUT_W = DATA_W
) (
  input  logic [IN_W-1:0]       a_i,
  input  logic [1:0]            mode_i,
  input  logic [OUT_W-IN_W-1:0] hi_i,
  output logic [OUT_W-1:0]      r_o
);

  localparam int unsigned HiW = OUT_W - IN_W;

  always_comb begin
    r_o = '0;
    unique case (mode_i)
      IMM_ZERO: r_o = {{HiW{1'b0}}, a_i};
      IMM_SIGN: r_o = {{HiW{a_i[IN_W-1]}}, a_i};
      IMM_LO:   r_o = {hi_i, a_i};
      default:  r_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Registered immediate extender with valid/ready handshake on both sides and a
// HI/LO combine path that assembles a full-width word from two beats.
module imm_extend_unit
  import imm_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_IN_W,
  parameter int unsigned OUT_W = DATA_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  A,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] R,
  output logic             hi_miss,
  output logic             hi_held
);

  localparam int unsigned HiW = OUT_W - IN_W;

  comb_state_e      state_q, state_d;
  logic [HiW-1:0]   hi_reg_q, hi_reg_d;
  logic [OUT_W-1:0] r_q, r_d, ext_r;
  logic             hi_miss_q, hi_miss_d;
  logic             out_valid_q, out_valid_d;
  logic             accept, emit;

  // Single output register: a drain and a refill may share one cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign emit     = accept && imm_produces_result(mode);

  imm_ext_comb #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .a_i    (A),
    .mode_i (mode),
    .hi_i   (hi_reg_q),
    .r_o    (ext_r)
  );

  // Combine FSM; hi_reg is cleared whenever the FSM leaves Held via LO.
  always_comb begin
    state_d  = state_q;
    hi_reg_d = hi_reg_q;
    if (accept) begin
      unique case (mode)
        IMM_HI: begin
          state_d  = StHeld;
          hi_reg_d = A[HiW-1:0];
        end
        IMM_LO: begin
          state_d  = StIdle;
          hi_reg_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    r_d         = r_q;
    hi_miss_d   = hi_miss_q;
    out_valid_d = emit || (out_valid_q && !out_ready);
    if (emit) begin
      r_d       = ext_r;
      hi_miss_d = (mode == IMM_LO) && (state_q == StIdle);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= StIdle;
      hi_reg_q    <= '0;
      r_q         <= '0;
      hi_miss_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_reg_q    <= hi_reg_d;
      r_q         <= r_d;
      hi_miss_q   <= hi_miss_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign R         = r_q;
  assign hi_miss   = hi_miss_q;
  assign hi_held   = (state_q == StHeld);

endmodule
